// File: rtl/router_sched.sv
// Round-robin burst scheduler: moves up to MAX_BURST words from one granted
// first-word-fall-through source into a shared destination FIFO.
module router_sched #(
    parameter int WIDTH     = 64,
    parameter int NUM_SRC   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_SRC-1:0]       src_empty,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]       src_pop,
    input  logic                     dst_full,
    input  logic                     dst_afull,
    output logic                     dst_push,
    output logic [WIDTH-1:0]         dst_data,
    output logic [NUM_SRC-1:0]       gnt,
    output logic                     busy,
    output logic [15:0]              xfer_cnt
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] cur, last, sel, cand;
    logic [BW-1:0] burst_cnt;
    logic          any_req, ok, last_word;

    // Walk from last+NUM_SRC down to last+1 so the nearest source after last wins.
    always_comb begin
        sel     = last;
        cand    = last;
        any_req = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NUM_SRC);
            if (!src_empty[cand]) begin
                sel     = cand;
                any_req = 1'b1;
            end
        end
    end

    // At most one word in flight when the destination is one slot from full.
    assign ok = reset && (state == XFER) && !src_empty[cur] && !dst_full &&
                (!dst_afull || !dst_push);
    assign last_word = (burst_cnt == BW'(MAX_BURST - 1));
    assign busy      = (state == XFER) || dst_push;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && any_req) state_nxt = XFER;
            XFER:    if (src_empty[cur] || (ok && last_word)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_pop      = '0;
        src_pop[cur] = ok;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt       <= '0;
            cur       <= '0;
            last      <= IW'(NUM_SRC - 1);
            burst_cnt <= '0;
            dst_push  <= 1'b0;
            dst_data  <= '0;
            xfer_cnt  <= '0;
        end else begin
            dst_push <= ok;
            if (ok) begin
                dst_data  <= src_data[cur*WIDTH +: WIDTH];
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (dst_push) xfer_cnt <= xfer_cnt + 16'd1;
            if (state == IDLE && state_nxt == XFER) begin
                cur       <= sel;
                gnt       <= NUM_SRC'(1) << sel;
                burst_cnt <= '0;
            end else if (state == XFER && state_nxt == IDLE) begin
                last <= cur;
                gnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_router_sched.sv
// Directed bench for router_sched: FWFT source models, pop/push scoreboard,
// and a second instance that walks xfer_cnt through its wrap point.
module tb_router_sched;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, en, dst_full, dst_afull;
    logic [1:0]     src_empty, src_pop, gnt;
    logic [2*W-1:0] src_data;
    logic           dst_push, busy;
    logic [W-1:0]   dst_data;
    logic [15:0]    xfer_cnt;

    router_sched #(.WIDTH(W), .NUM_SRC(2), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .en(en), .src_empty(src_empty), .src_data(src_data),
        .src_pop(src_pop), .dst_full(dst_full), .dst_afull(dst_afull), .dst_push(dst_push),
        .dst_data(dst_data), .gnt(gnt), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    logic [1:0]     w_empty, w_pop, w_gnt;
    logic [2*W-1:0] w_data;
    logic           w_push, w_busy;
    logic [W-1:0]   w_dout;
    logic [15:0]    w_cnt;
    int             w_pops  = 0;
    int             w_limit = 0;
    logic           w_en    = 1'b1;
    logic           w_zero  = 1'b0;

    assign w_empty = {1'b1, (w_pops >= w_limit)};
    assign w_data  = {64'd0, 32'd0, w_pops};
    always @(posedge clk) if (w_pop[0]) w_pops <= w_pops + 1;

    router_sched #(.WIDTH(W), .NUM_SRC(2), .MAX_BURST(16)) u_wrap (
        .clk(clk), .reset(reset), .en(w_en), .src_empty(w_empty), .src_data(w_data),
        .src_pop(w_pop), .dst_full(w_zero), .dst_afull(w_zero), .dst_push(w_push),
        .dst_data(w_dout), .gnt(w_gnt), .busy(w_busy), .xfer_cnt(w_cnt)
    );

    // Source i word k carries its origin so misrouted or repeated words stand out.
    function automatic logic [63:0] dword(input int i, input int k);
        return {16'hA5A5, i[7:0], 8'h00, k[31:0]};
    endfunction

    int head [2] = '{0, 0};
    int tail [2] = '{0, 0};
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_empty[i]       = (head[i] >= tail[i]);
            src_data[i*W +: W] = dword(i, head[i]);
        end
    end

    int           cyc     = 0;
    int           bad_pop = 0;
    int           pop_src [$];
    int           pop_cyc [$];
    logic [W-1:0] pop_dat [$];
    logic [W-1:0] push_dat [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((src_pop & ~gnt) != 2'b00 || (src_pop & src_empty) != 2'b00 || src_pop == 2'b11)
            bad_pop <= bad_pop + 1;
        for (int i = 0; i < 2; i++) begin
            if (src_pop[i]) begin
                head[i] <= head[i] + 1;
                pop_src.push_back(i);
                pop_cyc.push_back(cyc);
                pop_dat.push_back(src_data[i*W +: W]);
            end
        end
        if (dst_push) push_dat.push_back(dst_data);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int exp_src [20] = '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0, 1,1};
    int exp_off [20] = '{0,1,2,3, 5,6,7,8, 10,11,12,13, 15,16,17,18, 20,21, 24,25};

    initial begin
        int pb, got_src, got_off, guard;
        reset = 1'b0; en = 1'b0; dst_full = 1'b0; dst_afull = 1'b0;
        step(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_pop", src_pop, 0);
        chk("rst_push", dst_push, 0);
        chk("rst_data", dst_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xcnt", xfer_cnt, 0);
        @(negedge clk); reset = 1'b1; #1;
        step();

        // single source, 3 words
        @(negedge clk); tail[0] = 3; en = 1'b1; #1;
        chk("s1_gnt_t0", gnt, 0);
        step(); chk("s1_gnt_t1", gnt, 2'b01); chk("s1_pop_t1", src_pop, 2'b01);
        chk("s1_push_t1", dst_push, 0); chk("s1_busy_t1", busy, 1);
        step(); chk("s1_pop_t2", src_pop, 2'b01); chk("s1_push_t2", dst_push, 1);
        chk("s1_data_t2", dst_data, dword(0, 0));
        step(); chk("s1_pop_t3", src_pop, 2'b01); chk("s1_data_t3", dst_data, dword(0, 1));
        step(); chk("s1_pop_t4", src_pop, 0); chk("s1_push_t4", dst_push, 1);
        chk("s1_data_t4", dst_data, dword(0, 2));
        step(); chk("s1_gnt_t5", gnt, 0); chk("s1_push_t5", dst_push, 0);
        chk("s1_xcnt", xfer_cnt, 3); chk("s1_busy_t5", busy, 0);

        // enable low holds off arbitration; dropping it mid-burst does not cut the burst
        @(negedge clk); en = 1'b0; tail[0] = 9; #1;
        for (int i = 0; i < 10; i++) begin step(); chk("en0_gnt", gnt, 0); end
        @(negedge clk); en = 1'b1; #1;
        @(negedge clk); en = 1'b0; #1;
        chk("en_gnt", gnt, 2'b01); chk("en_pop1", src_pop, 2'b01);
        for (int i = 0; i < 3; i++) begin step(); chk("en_pop", src_pop, 2'b01); end
        step(); chk("en_end_gnt", gnt, 0); chk("en_end_pop", src_pop, 0);
        for (int i = 0; i < 5; i++) begin step(); chk("en_hold_gnt", gnt, 0); end
        chk("en_xcnt", xfer_cnt, 7);

        // back-pressure: afull with a push in flight, then full for 5 cycles
        @(negedge clk); en = 1'b1; tail[0] = 15; #1;
        step(); chk("bp_gnt", gnt, 2'b01); chk("bp_pop1", src_pop, 2'b01);
        @(negedge clk); dst_afull = 1'b1; #1;
        chk("bp_afull_push", dst_push, 1); chk("bp_afull_pop", src_pop, 0);
        step(); chk("bp_afull_idle_push", dst_push, 0); chk("bp_pop2", src_pop, 2'b01);
        @(negedge clk); dst_afull = 1'b0; dst_full = 1'b1; #1;
        chk("bp_full_pop", src_pop, 0);
        for (int i = 0; i < 4; i++) begin
            step(); chk("bp_full_pop", src_pop, 0); chk("bp_full_push", dst_push, 0);
            chk("bp_full_gnt", gnt, 2'b01);
        end
        @(negedge clk); dst_full = 1'b0; #1;
        chk("bp_pop3", src_pop, 2'b01);
        @(negedge clk); en = 1'b0; #1;
        chk("bp_pop4", src_pop, 2'b01);
        step(); chk("bp_end_gnt", gnt, 0); chk("bp_end_pop", src_pop, 0);
        step(); chk("bp_xcnt", xfer_cnt, 11);

        // fairness: 10 words on each source from a fresh reset
        @(negedge clk); reset = 1'b0; #1;
        @(negedge clk); reset = 1'b1; #1;
        pb = pop_src.size();
        @(negedge clk); tail[0] = head[0] + 10; tail[1] = head[1] + 10; en = 1'b1; #1;
        step(32);
        chk("fair_npop", pop_src.size() - pb, 20);
        for (int j = 0; j < 20; j++) begin
            got_src = (pb + j < pop_src.size()) ? pop_src[pb + j] : -1;
            got_off = (pb + j < pop_cyc.size()) ? pop_cyc[pb + j] - pop_cyc[pb] : -1;
            chk($sformatf("fair_src%0d", j), got_src, exp_src[j]);
            chk($sformatf("fair_off%0d", j), got_off, exp_off[j]);
        end
        chk("fair_xcnt", xfer_cnt, 20);

        // reset one cycle after a pop
        @(negedge clk); tail[1] = head[1] + 3; #1;
        step(); chk("rm_gnt", gnt, 2'b10); chk("rm_pop", src_pop, 2'b10);
        @(negedge clk); reset = 1'b0; #1;
        chk("rm_pop_in_reset", src_pop, 0);
        @(negedge clk); tail[0] = head[0] + 2; #1;
        chk("rm_push", dst_push, 0); chk("rm_gnt0", gnt, 0);
        chk("rm_xcnt", xfer_cnt, 0); chk("rm_busy", busy, 0);
        @(negedge clk); reset = 1'b1; #1;
        step(); chk("rm_first_gnt", gnt, 2'b01);
        step(15);
        @(negedge clk); en = 1'b0; #1;
        step(3);

        // every popped word reaches the destination once, in order
        chk("sb_count", push_dat.size(), pop_dat.size());
        for (int j = 0; j < pop_dat.size(); j++)
            chk($sformatf("sb_word%0d", j), (j < push_dat.size()) ? push_dat[j] : 'x, pop_dat[j]);
        chk("pop_rules", bad_pop, 0);

        // xfer_cnt wrap
        @(negedge clk); w_limit = 65535; #1;
        guard = 0;
        while (w_cnt !== 16'hFFFF && guard < 80000) begin step(); guard++; end
        chk("wrap_ffff", w_cnt, 16'hFFFF);
        step(5);
        chk("wrap_hold", w_cnt, 16'hFFFF); chk("wrap_idle", w_busy, 0); chk("wrap_gnt", w_gnt, 0);
        @(negedge clk); w_limit = 65537; #1;
        step(2); chk("wrap_push", w_push, 1); chk("wrap_data", w_dout, 65535);
        step(); chk("wrap_0000", w_cnt, 16'h0000);
        step(); chk("wrap_0001", w_cnt, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
